seg_scan_display: RTL and testbench



---
 rtl/seg_display_pkg.sv | 36 +++
 rtl/bin2bcd_seq.sv | 93 +++++++++
 rtl/seg_scan_display.sv | 131 +++++++++++++
 tb/tb_seg_scan_display.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants, FSM state type and helpers for the multiplexed 7-segment display.
// Segment codes are active-low, bit6=g ... bit0=a.
package seg_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

    // Non-decimal nibbles render as blank rather than an arbitrary pattern.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] nib);
        if (nib > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[nib];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
// done pulses for one cycle in COMMIT, when bcd_out and overflow are final.
module bin2bcd_seq
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int IN_WIDTH   = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IN_WIDTH-1:0]     value_in,
    input  logic                    load,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] bcd_out
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH);
    localparam logic [31:0] OVF_LIMIT = pow10(NUM_DIGITS);

    conv_state_t         state_reg;
    logic [IN_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [BCD_W-1:0]    bcd_reg;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_next;
    logic                busy_reg;
    logic                done_reg;
    logic                ovf_reg;
    logic [31:0]         value_ext;
    logic                accept;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Bits leaving the top of the scratch register are dropped; overflow flags that case.
    assign bcd_next  = {bcd_adj[BCD_W-2:0], shift_reg[IN_WIDTH-1]};
    assign value_ext = 32'(value_in);
    // A new value may be taken in the commit cycle, back to back with the previous one.
    assign accept    = load && (state_reg != SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            bcd_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                SHIFT: begin
                    bcd_reg   <= bcd_next;
                    shift_reg <= {shift_reg[IN_WIDTH-2:0], 1'b0};
                    if (cnt_reg == '0) begin
                        state_reg <= COMMIT;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        shift_reg <= value_in;
                        bcd_reg   <= '0;
                        cnt_reg   <= CNT_W'(IN_WIDTH - 1);
                        ovf_reg   <= (value_ext >= OVF_LIMIT);
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign overflow = ovf_reg;
    assign bcd_out  = bcd_reg;

endmodule

// File: rtl/seg_scan_display.sv
// Multi-digit common-anode 7-segment driver: BCD conversion, latching and digit scanning.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_display
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int IN_WIDTH    = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   value_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [BCD_W-1:0]      bcd_out;
    logic                  conv_done;
    logic                  conv_ovf;
    logic [BCD_W-1:0]      display_reg;
    logic                  overflow_reg;
    logic [REF_W-1:0]      refresh_reg;
    logic [IDX_W-1:0]      digit_idx_reg;
    logic [6:0]            seg_reg;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_reg;
    logic [NUM_DIGITS-1:0] an_next;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [3:0]            digit_nib [NUM_DIGITS];

    bin2bcd_seq #(
        .NUM_DIGITS(NUM_DIGITS),
        .IN_WIDTH  (IN_WIDTH)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .value_in(value_in),
        .load    (load),
        .busy    (busy),
        .done    (conv_done),
        .overflow(conv_ovf),
        .bcd_out (bcd_out)
    );

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign digit_nib[gi] = display_reg[gi*4 +: 4];
        end
    endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_mask_reg;
    logic [NUM_DIGITS-1:0] blank_mask_next;

    // A digit is blank when it and everything above it are zero; digit 0 is never blank.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign blank_mask_next[gi] = 1'b0;
            end else begin : g_upper
                assign blank_mask_next[gi] = ((bcd_out >> (4 * gi)) == '0);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_mask_reg <= '0;
        end else if (conv_done) begin
            blank_mask_reg <= blank_mask_next;
        end
    end

    assign blank_mask = blank_mask_reg;
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        seg_next = digit_to_seg(digit_nib[digit_idx_reg]);
        if (overflow_reg) begin
            seg_next = SEG_DASH;
        end else if (blank_mask[digit_idx_reg]) begin
            seg_next = SEG_BLANK;
        end
    end

    assign an_next = ~(NUM_DIGITS'(1) << digit_idx_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_reg   <= '0;
            digit_idx_reg <= '0;
            seg_reg       <= SEG_BLANK;
            an_reg        <= '1;
            display_reg   <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            if (refresh_reg == REF_W'(REFRESH_DIV - 1)) begin
                refresh_reg <= '0;
                if (digit_idx_reg == IDX_W'(NUM_DIGITS - 1)) begin
                    digit_idx_reg <= '0;
                end else begin
                    digit_idx_reg <= digit_idx_reg + 1'b1;
                end
            end else begin
                refresh_reg <= refresh_reg + 1'b1;
            end

            seg_reg <= seg_next;
            an_reg  <= an_next;

            if (conv_done) begin
                display_reg  <= bcd_out;
                overflow_reg <= conv_ovf;
            end
        end
    end

    assign seg      = seg_reg;
    assign an       = an_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: directed and random loads against a decimal-arithmetic model.
// Honours SEG_LEADING_ZERO_BLANK_EN when the build defines it.
module tb_seg_scan_display;

    localparam int N   = 4;
    localparam int W   = 14;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] value_in = '0;
    logic         load = 1'b0;
    logic         busy;
    logic         overflow;
    logic [6:0]   seg;
    logic [N-1:0] an;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc;
    int disp_val = 0;
    bit disp_ovf = 1'b0;

    logic [6:0] digit_tbl [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    seg_scan_display #(
        .NUM_DIGITS (N),
        .IN_WIDTH   (W),
        .REFRESH_DIV(DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value_in(value_in),
        .load    (load),
        .busy    (busy),
        .overflow(overflow),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; edge k shows digit ((k-1)/DIV) % N.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] model_seg(input int val, input bit ovf, input int d);
        if (ovf) return 7'b0111111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (d > 0 && val < p10(d)) return 7'b1111111;
`endif
        return digit_tbl[(val / p10(d)) % 10];
    endfunction

    function automatic logic [31:0] scan_exp();
        int idx;
        logic [N-1:0] an_e;
        idx  = ((cyc - 1) / DIV) % N;
        an_e = '1;
        an_e[idx] = 1'b0;
        return {21'd0, an_e, model_seg(disp_val, disp_ovf, idx)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_scan(input string tag, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            check(tag, {21'd0, an, seg}, scan_exp());
        end
    endtask

    // Called at a falling edge; drives load for one rising edge and follows the conversion.
    task automatic do_load(input int v, input bit inject, input int inj_v,
                           input bit chk_hold, input bit settle);
        int bcnt;
        value_in = W'(v);
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 40) begin
            bcnt++;
            if (chk_hold) check("hold_prev", {21'd0, an, seg}, scan_exp());
            if (inject && bcnt == 3) begin
                value_in = W'(inj_v);
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        check("busy_len", bcnt, W);
        disp_val = v;
        disp_ovf = (v >= p10(N));
        if (settle) begin
            repeat (2) @(negedge clk);
            check("overflow", {31'd0, overflow}, {31'd0, disp_ovf});
            check_scan("scan", N * DIV);
        end
    endtask

    initial begin
        int v;
        repeat (3) @(negedge clk);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        check_scan("post_rst", 6);

        // Asynchronous reset in the middle of a scan slot.
        #2 rst = 1'b1;
        #1;
        check("async_seg", {25'd0, seg}, 32'h7F);
        check("async_an", {28'd0, an}, 32'hF);
        @(negedge clk);
        check("held_an", {28'd0, an}, 32'hF);
        rst = 1'b0;
        check_scan("after_rst", 3);

        do_load(1234, 1'b0, 0, 1'b1, 1'b1);
        do_load(10000, 1'b0, 0, 1'b1, 1'b1);
        do_load(9999, 1'b0, 0, 1'b1, 1'b1);
        do_load(7, 1'b1, 42, 1'b1, 1'b1);
        do_load(5, 1'b0, 0, 1'b1, 1'b1);
        do_load(0, 1'b0, 0, 1'b1, 1'b1);
        do_load(16383, 1'b0, 0, 1'b1, 1'b1);
        do_load(60, 1'b0, 0, 1'b1, 1'b1);

        // Reset while the converter is shifting aborts it and clears the display.
        value_in = W'(500);
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_mid", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        disp_val = 0;
        disp_ovf = 1'b0;
        check_scan("abort_scan", N * DIV);
        do_load(77, 1'b0, 0, 1'b1, 1'b1);

        // Next load lands on the commit edge of the previous conversion.
        do_load(321, 1'b0, 0, 1'b1, 1'b0);
        do_load(4567, 1'b0, 0, 1'b0, 1'b1);

        for (int t = 0; t < 12; t++) begin
            v = (t % 4 == 3) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
            do_load(v, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 16383)), 1'b1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (%0d/%0d checks passed)", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
